ntt_stage_sequencer: RTL and testbench
======================================

// Module: ntt_stage_sequencer
// PURPOSE
// Parametrised NTT iteration sequencer. It drives the TF generator, AGU, bank memory and NTT datapath through a
// run-time selectable number of radix iterations (1..MAX_ITE). Each iteration issues BU_PER_ITE butterfly reads,
// then drains until BU_PER_ITE writes have retired. It then commits the twiddle base (TF_wen) and advances the stage.
// It sits between top-level start/done control and the TF_gen, AGU_top, memory and ntt blocks.
// PARAMETERS
// D_WIDTH      16   width of it_depth_cnt, bu_cnt, wr_cnt, init counter
// MAX_ITE      3    maximum number of NTT iterations supported
// BU_PER_ITE   64   butterfly groups read/written per iteration (>=2)
// INIT_CYCLES  256  TF/AGU initialisation cycles after start (>=1); equals `degree
// PORTS
// clk            in   1        single clock, rising edge
// rst            in   1        synchronous reset, active-high
// start          in   1        begin a transform; sampled only in IDLE
// ite_num        in   D_WIDTH  iterations to run; latched on accepted start
// BN_MA_out_en   in   1        AGU has a valid read address this cycle
// ntt_done       in   1        datapath result valid this cycle (one write)
// TF_init_base   out  1        TF base initialise strobe
// TF_init_const  out  1        TF constant initialise strobe
// TF_ren         out  1        TF read, one per butterfly read
// TF_wen         out  1        TF base commit, one pulse per iteration
// it_depth_cnt   out  D_WIDTH  current iteration index (0-based)
// AGU_enable     out  1        AGU running
// r_enable       out  1        memory read strobe
// w_enable       out  1        memory write strobe
// ntt_enable     out  1        r_enable delayed one cycle (read data valid at datapath)
// busy           out  1        high in any state except IDLE
// done           out  1        one-cycle pulse when the final iteration completes
// err            out  1        sticky: unexpected ntt_done; cleared by rst or accepted start
// BEHAVIOUR
// Reset: synchronous, active-high; all outputs 0, state IDLE, counters 0. Reset mid-run aborts with no done pulse.
// ite_num latch: accepted start latches ite_eff = (ite_num==0) ? 1 : min(ite_num, MAX_ITE). start while busy is ignored.
// States:
// - IDLE: start -> INIT.
// - INIT: TF_init_base=TF_init_const=1 every cycle. init_cnt counts 0..INIT_CYCLES-1; at INIT_CYCLES-1 -> READ.
//   init_cnt, bu_cnt, wr_cnt and stage are all 0 on entering READ.
// - READ: AGU_enable=1; r_enable=TF_ren=BN_MA_out_en; each read increments bu_cnt.
//   A read with bu_cnt==BU_PER_ITE-1 wraps bu_cnt to 0 -> DRAIN.
// - DRAIN: AGU_enable=1, no reads. -> COMMIT on the cycle wr_cnt reaches BU_PER_ITE, i.e. the write taking
//   wr_cnt to BU_PER_ITE. If wr_cnt already equals BU_PER_ITE on entry, DRAIN still lasts one cycle.
// - COMMIT: TF_wen=1 for exactly one cycle; wr_cnt<=0.
//   If stage==ite_eff-1 -> DONE, else stage<=stage+1 -> READ.
// - DONE: done=1 for one cycle, stage<=0 -> IDLE.
// Writes:
// - w_enable = ntt_done && state in {READ,DRAIN} && wr_cnt<BU_PER_ITE. Each write increments wr_cnt.
// - Writes may overlap reads; a write in the same cycle as the final read is counted.
// - ntt_done when w_enable would be 0 (wrong state or wr_cnt full): no write, err<=1.
// it_depth_cnt=stage in READ/DRAIN/COMMIT, else 0. ntt_enable is a register of r_enable, cleared by rst.
// Counters never exceed their terminal values; there is no wrap beyond the bounds above.
// TESTING
// 1 INIT_CYCLES=4, BU=4, ite_num=1, BN_MA_out_en=1 always, ntt_done 3 cycles after each read ->
//   4 INIT cycles; r_enable pulses 4 times; TF_wen 1 pulse; done 1 cycle; err=0.
// 2 ite_num=3, BU=4 -> TF_wen 3 pulses; it_depth_cnt 0,1,2; 12 r_enable and 12 w_enable pulses; single done.
// 3 ite_num=0 and ite_num=7 with MAX_ITE=3 -> 1 and 3 iterations respectively.
// 4 BN_MA_out_en toggling 1,0 -> r_enable only when high; bu_cnt holds when low; still 4 reads per stage.
// 5 extra ntt_done in IDLE -> w_enable=0, err=1 until next start. rst asserted in DRAIN -> IDLE next cycle,
//   all outputs 0, no done pulse.
// 6 start asserted while busy -> ignored; ite_num changed mid-run -> no effect on the running transform.

Source files
------------

// File: rtl/ntt_stage_sequencer.sv
// NTT iteration sequencer: INIT, then per-stage READ/DRAIN/COMMIT
// passes over BU_PER_ITE butterflies, finishing with a done pulse.
module ntt_stage_sequencer #(
    parameter int D_WIDTH     = 16,
    parameter int MAX_ITE     = 3,
    parameter int BU_PER_ITE  = 64,
    parameter int INIT_CYCLES = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [D_WIDTH-1:0] ite_num,
    input  logic               BN_MA_out_en,
    input  logic               ntt_done,
    output logic               TF_init_base,
    output logic               TF_init_const,
    output logic               TF_ren,
    output logic               TF_wen,
    output logic [D_WIDTH-1:0] it_depth_cnt,
    output logic               AGU_enable,
    output logic               r_enable,
    output logic               w_enable,
    output logic               ntt_enable,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_READ,
        S_DRAIN,
        S_COMMIT,
        S_DONE
    } state_t;

    localparam logic [D_WIDTH-1:0] ONE       = D_WIDTH'(1);
    localparam logic [D_WIDTH-1:0] BU_LAST   = D_WIDTH'(BU_PER_ITE - 1);
    localparam logic [D_WIDTH-1:0] BU_FULL   = D_WIDTH'(BU_PER_ITE);
    localparam logic [D_WIDTH-1:0] INIT_LAST = D_WIDTH'(INIT_CYCLES - 1);
    localparam logic [D_WIDTH-1:0] ITE_MAX   = D_WIDTH'(MAX_ITE);

    state_t             state;
    logic [D_WIDTH-1:0] init_cnt;
    logic [D_WIDTH-1:0] bu_cnt;
    logic [D_WIDTH-1:0] wr_cnt;
    logic [D_WIDTH-1:0] stage;
    logic [D_WIDTH-1:0] ite_eff;
    logic [D_WIDTH-1:0] ite_sat;
    logic               err_q;
    logic               ntt_en_q;
    logic               active;

    assign ite_sat = (ite_num == '0) ? ONE :
                     (ite_num > ITE_MAX) ? ITE_MAX : ite_num;

    assign active        = (state == S_READ) || (state == S_DRAIN);
    assign r_enable      = (state == S_READ) && BN_MA_out_en;
    assign w_enable      = ntt_done && active && (wr_cnt < BU_FULL);
    assign TF_ren        = r_enable;
    assign TF_init_base  = (state == S_INIT);
    assign TF_init_const = (state == S_INIT);
    assign TF_wen        = (state == S_COMMIT);
    assign AGU_enable    = active;
    assign done          = (state == S_DONE);
    assign busy          = (state != S_IDLE);
    assign ntt_enable    = ntt_en_q;
    assign err           = err_q;
    assign it_depth_cnt  = (active || state == S_COMMIT) ? stage : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            init_cnt <= '0;
            bu_cnt   <= '0;
            wr_cnt   <= '0;
            stage    <= '0;
            ite_eff  <= '0;
            err_q    <= 1'b0;
            ntt_en_q <= 1'b0;
        end else begin
            ntt_en_q <= r_enable;
            if (state == S_IDLE && start)
                err_q <= 1'b0;
            // a stray result outranks the clear of a same-cycle start
            if (ntt_done && !w_enable)
                err_q <= 1'b1;
            if (w_enable)
                wr_cnt <= wr_cnt + ONE;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ite_eff  <= ite_sat;
                        init_cnt <= '0;
                        state    <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        init_cnt <= '0;
                        bu_cnt   <= '0;
                        wr_cnt   <= '0;
                        stage    <= '0;
                        state    <= S_READ;
                    end else begin
                        init_cnt <= init_cnt + ONE;
                    end
                end
                S_READ: begin
                    if (r_enable) begin
                        if (bu_cnt == BU_LAST) begin
                            bu_cnt <= '0;
                            state  <= S_DRAIN;
                        end else begin
                            bu_cnt <= bu_cnt + ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (wr_cnt == BU_FULL ||
                        (w_enable && wr_cnt == BU_LAST))
                        state <= S_COMMIT;
                end
                S_COMMIT: begin
                    wr_cnt <= '0;
                    if (stage == ite_eff - ONE) begin
                        state <= S_DONE;
                    end else begin
                        stage <= stage + ONE;
                        state <= S_READ;
                    end
                end
                S_DONE: begin
                    stage <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Scoreboard bench for ntt_stage_sequencer: expected commit/done
// events are queued at start, a monitor pops them on TF_wen/done.
module tb_ntt_stage_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] ite_num = '0;
    logic        BN_MA_out_en = 1'b0;
    logic        ntt_done = 1'b0;
    logic        TF_init_base, TF_init_const, TF_ren, TF_wen;
    logic [15:0] it_depth_cnt;
    logic        AGU_enable, r_enable, w_enable, ntt_enable;
    logic        busy, done, err;

    always #5 clk = ~clk;

    ntt_stage_sequencer #(
        .D_WIDTH(16),
        .MAX_ITE(3),
        .BU_PER_ITE(4),
        .INIT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .ite_num(ite_num),
        .BN_MA_out_en(BN_MA_out_en),
        .ntt_done(ntt_done),
        .TF_init_base(TF_init_base),
        .TF_init_const(TF_init_const),
        .TF_ren(TF_ren),
        .TF_wen(TF_wen),
        .it_depth_cnt(it_depth_cnt),
        .AGU_enable(AGU_enable),
        .r_enable(r_enable),
        .w_enable(w_enable),
        .ntt_enable(ntt_enable),
        .busy(busy),
        .done(done),
        .err(err)
    );

    typedef struct {
        bit is_done;
        int stage;
        int rd;
        int wr;
        int init;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Datapath model: every read returns a result three cycles later.
    bit       en_toggle = 1'b0;
    bit       extra_done = 1'b0;
    bit       ph = 1'b0;
    bit [2:0] pipe = '0;

    always @(negedge clk) begin
        ntt_done = rst ? 1'b0 : (pipe[2] | extra_done);
        if (rst)
            pipe = '0;
        ph = ~ph;
        BN_MA_out_en = en_toggle ? ph : 1'b1;
        #1;
        pipe = {pipe[1:0], r_enable};
    end

    int   rd_c = 0;
    int   wr_c = 0;
    int   init_c = 0;
    bit   prev_done = 1'b0;
    bit   prev_r = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            rd_c = 0;
            wr_c = 0;
            init_c = 0;
            prev_done = 1'b0;
            prev_r = 1'b0;
        end else begin
            chk("ntt_enable", int'(ntt_enable), int'(prev_r));
            if (!BN_MA_out_en)
                chk("r_enable_gated", int'(r_enable), 0);
            if (r_enable || TF_ren)
                chk("tf_ren", int'(TF_ren), int'(r_enable));
            if (TF_init_base || TF_init_const)
                chk("init_const", int'(TF_init_const), int'(TF_init_base));
            if (TF_init_base)
                init_c++;
            if (r_enable)
                rd_c++;
            if (w_enable)
                wr_c++;
            if (TF_wen || done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: TF_wen=%0b done=%0b",
                             TF_wen, done);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", int'(done), int'(e.is_done));
                    if (!e.is_done) begin
                        chk("stage", int'(it_depth_cnt), e.stage);
                        chk("reads", rd_c, e.rd);
                        chk("writes", wr_c, e.wr);
                    end else begin
                        chk("done_depth", int'(it_depth_cnt), 0);
                        chk("init_cycles", init_c, e.init);
                        chk("done_err", int'(err), 0);
                    end
                end
                if (TF_wen) begin
                    rd_c = 0;
                    wr_c = 0;
                end
                if (done)
                    init_c = 0;
            end
            if (prev_done)
                chk("done_width", int'(done), 0);
            prev_done = done;
            prev_r = r_enable;
        end
    end

    function automatic int out_vec();
        return int'({TF_init_base, TF_init_const, TF_ren, TF_wen,
                     AGU_enable, r_enable, w_enable, ntt_enable,
                     busy, done, err, it_depth_cnt});
    endfunction

    task automatic run(input int num, input int iters);
        for (int s = 0; s < iters; s++)
            sb.push_back('{1'b0, s, 4, 4, 0});
        sb.push_back('{1'b1, 0, 0, 0, 4});
        @(posedge clk);
        #1;
        start = 1'b1;
        ite_num = 16'(num);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d events left, expected 0",
                     name, sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", out_vec(), 0);
        rst = 1'b0;

        run(1, 1);
        wait_empty("ite1");
        run(3, 3);
        wait_empty("ite3");
        run(0, 1);
        wait_empty("ite0");
        run(7, 3);
        wait_empty("ite7");

        en_toggle = 1'b1;
        run(3, 3);
        wait_empty("toggle");
        en_toggle = 1'b0;

        @(posedge clk);
        #1;
        extra_done = 1'b1;
        @(negedge clk);
        #2;
        chk("w_enable_idle", int'(w_enable), 0);
        @(posedge clk);
        #1;
        extra_done = 1'b0;
        chk("err_set", int'(err), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", int'(err), 1);
        run(1, 1);
        chk("err_cleared", int'(err), 0);
        wait_empty("after_err");

        run(1, 1);
        begin
            int n = 0;
            while (rd_c < 4 && n < 100) begin
                @(posedge clk);
                n++;
            end
        end
        #1;
        chk("drain_agu", int'(AGU_enable), 1);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        chk("reset_in_drain", out_vec(), 0);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("reset_no_done", out_vec(), 0);

        run(2, 2);
        repeat (6) @(posedge clk);
        #1;
        start = 1'b1;
        ite_num = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_empty("busy_start");
        repeat (4) @(posedge clk);
        #1;
        chk("no_restart", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
